// File: rtl/mips_cpu_pkg.sv
// Shared CPU constants and types for the register-file write-back path.
// Requester indices fix the write-port priority order of the arbiter.
package mips_cpu_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mips_cpu_wb_arb_core.sv
// One-hot grant picker: the first valid requester found, searching upward
// from i_ptr and wrapping around. A pointer held at zero gives fixed priority.
module mips_cpu_wb_arb_core
    import mips_cpu_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    localparam int SW = PW + 1;

    logic [SW-1:0] w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N))
                w_sum = w_sum - SW'(N);
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Register-file write-port arbiter with a busy scoreboard for long-latency ops.
// Define MIPS_WB_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module mips_cpu_regfile_wb_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int REG_AW = mips_cpu_pkg::REG_AW,
    parameter int DATA_W = mips_cpu_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*REG_AW-1:0]   i_req_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic                      i_issue_valid,
    input  logic [REG_AW-1:0]         i_issue_dest,
    input  logic [REG_AW-1:0]         i_chk_r1,
    input  logic [REG_AW-1:0]         i_chk_r2,
    output logic                      o_hazard,
    output logic                      o_rf_write_enable,
    output logic [REG_AW-1:0]         o_rf_write_r,
    output logic [DATA_W-1:0]         o_rf_write_data,
    output logic [NUM_REGS-1:0]       o_busy_vec
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    w_core_grant;
    logic [N_REQ-1:0]    w_grant;
    logic [PW-1:0]       w_ptr;
    logic                w_any;
    logic [REG_AW-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_emit;
    logic [NUM_REGS-1:0] w_busy_next;

    logic                r_we;
    logic [REG_AW-1:0]   r_wr;
    logic [DATA_W-1:0]   r_wd;
    logic [NUM_REGS-1:0] r_busy;

    mips_cpu_wb_arb_core #(.N(N_REQ), .PW(PW)) u_core (
        .i_valid (i_req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_core_grant)
    );

    assign w_grant     = reset ? '0 : w_core_grant;
    assign o_req_ready = w_grant;

    always_comb begin
        w_any      = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_any      = 1'b1;
                w_sel_addr = i_req_addr[i*REG_AW +: REG_AW];
                w_sel_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // $0 writes are consumed here so the register file never sees them
    assign w_emit = w_any && (w_sel_addr != '0);

`ifdef MIPS_WB_ARB_RR_EN
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gidx;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_grant[i])
                w_gidx = PW'(i);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (w_any)
            r_ptr <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // A fresh issue outranks the completing write so the new producer stays tracked
    always_comb begin
        w_busy_next = r_busy;
        if (r_we)
            w_busy_next[r_wr] = 1'b0;
        if (i_issue_valid && (i_issue_dest != '0))
            w_busy_next[i_issue_dest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_wr   <= '0;
            r_wd   <= '0;
            r_busy <= '0;
        end else begin
            r_we   <= w_emit;
            r_busy <= w_busy_next;
            if (w_emit) begin
                r_wr <= w_sel_addr;
                r_wd <= w_sel_data;
            end
        end
    end

    assign o_hazard = ((i_chk_r1 != '0) && r_busy[i_chk_r1]) ||
                      ((i_chk_r2 != '0) && r_busy[i_chk_r2]);

    assign o_rf_write_enable = r_we;
    assign o_rf_write_r      = r_wr;
    assign o_rf_write_data   = r_wd;
    assign o_busy_vec        = r_busy;

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Directed bench for the write-back arbiter: grants, latency, scoreboard, hazard.
module tb_mips_cpu_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [4:0]  chk_r1;
    logic [4:0]  chk_r2;
    logic        hazard;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] busy;

    int nvec = 0;
    int nmis = 0;

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;
    localparam logic [31:0] DC = 32'hCCCC_0003;
    localparam logic [31:0] DD = 32'hDDDD_0004;
    localparam logic [31:0] DE = 32'hEEEE_0005;

    mips_cpu_regfile_wb_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_addr        (req_addr),
        .i_req_data        (req_data),
        .i_issue_valid     (issue_valid),
        .i_issue_dest      (issue_dest),
        .i_chk_r1          (chk_r1),
        .i_chk_r2          (chk_r2),
        .o_hazard          (hazard),
        .o_rf_write_enable (we),
        .o_rf_write_r      (wr),
        .o_rf_write_data   (wd),
        .o_busy_vec        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 3'b111;
        set_req(0, 5'd3, DA);
        set_req(1, 5'd4, DB);
        set_req(2, 5'd5, DC);
        for (int c = 0; c < 2; c++) begin
            tick();
            nvec++; if (req_ready !== 3'b000) begin nmis++; $display("FAIL reset_ready got=%b want=000", req_ready); end
            nvec++; if (we !== 1'b0) begin nmis++; $display("FAIL reset_we got=%b want=0", we); end
            nvec++; if (busy !== 32'h0) begin nmis++; $display("FAIL reset_busy got=%h want=0", busy); end
            nvec++; if (wr !== 5'd0 || wd !== 32'h0) begin nmis++; $display("FAIL reset_wrwd got=%0d/%h want=0/0", wr, wd); end
        end
        reset = 1'b0;
        #1;
        nvec++; if (req_ready !== 3'b001) begin nmis++; $display("FAIL release_ready got=%b want=001", req_ready); end
        tick();
        nvec++; if (we !== 1'b1 || wr !== 5'd3 || wd !== DA) begin nmis++; $display("FAIL release_write got=%b/%0d/%h want=1/3/%h", we, wr, wd, DA); end
    endtask

    task automatic test_fixed_priority();
        for (int c = 0; c < 2; c++) begin
            nvec++; if (req_ready !== 3'b001) begin nmis++; $display("FAIL fixed_hold_ready got=%b want=001", req_ready); end
            tick();
            nvec++; if (we !== 1'b1 || wr !== 5'd3 || wd !== DA) begin nmis++; $display("FAIL fixed_hold_write got=%b/%0d/%h want=1/3/%h", we, wr, wd, DA); end
        end
        req_valid = 3'b110;
        #1;
        nvec++; if (req_ready !== 3'b010) begin nmis++; $display("FAIL fixed_next_ready got=%b want=010", req_ready); end
        tick();
        nvec++; if (we !== 1'b1 || wr !== 5'd4 || wd !== DB) begin nmis++; $display("FAIL fixed_next_write got=%b/%0d/%h want=1/4/%h", we, wr, wd, DB); end
        req_valid = 3'b000;
        #1;
        nvec++; if (req_ready !== 3'b000) begin nmis++; $display("FAIL idle_ready got=%b want=000", req_ready); end
        tick();
        nvec++; if (we !== 1'b0 || wr !== 5'd4 || wd !== DB) begin nmis++; $display("FAIL idle_hold got=%b/%0d/%h want=0/4/%h", we, wr, wd, DB); end
    endtask

`ifdef MIPS_WB_ARB_RR_EN
    task automatic test_round_robin();
        logic [2:0] exp_rdy [4];
        logic [4:0] exp_wr  [4];
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100; exp_rdy[3] = 3'b001;
        exp_wr[0]  = 5'd3;   exp_wr[1]  = 5'd4;   exp_wr[2]  = 5'd5;   exp_wr[3]  = 5'd3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            nvec++; if (req_ready !== exp_rdy[k]) begin nmis++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, req_ready, exp_rdy[k]); end
            tick();
            nvec++; if (we !== 1'b1 || wr !== exp_wr[k]) begin nmis++; $display("FAIL rr_write[%0d] got=%b/%0d want=1/%0d", k, we, wr, exp_wr[k]); end
        end
        req_valid = 3'b000;
        tick();
    endtask
`endif

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_dest  = 5'd8;
        tick();
        issue_valid = 1'b0;
        nvec++; if (busy !== 32'h0000_0100) begin nmis++; $display("FAIL sb_set got=%h want=00000100", busy); end
        chk_r1 = 5'd8;
        #1;
        nvec++; if (hazard !== 1'b1) begin nmis++; $display("FAIL sb_hazard got=%b want=1", hazard); end
        set_req(2, 5'd8, DD);
        req_valid = 3'b100;
        #1;
        nvec++; if (req_ready !== 3'b100) begin nmis++; $display("FAIL sb_ready got=%b want=100", req_ready); end
        tick();
        req_valid = 3'b000;
        nvec++; if (we !== 1'b1 || wr !== 5'd8 || wd !== DD) begin nmis++; $display("FAIL sb_write got=%b/%0d/%h want=1/8/%h", we, wr, wd, DD); end
        nvec++; if (hazard !== 1'b1) begin nmis++; $display("FAIL sb_hazard_pending got=%b want=1", hazard); end
        tick();
        nvec++; if (hazard !== 1'b0 || busy !== 32'h0) begin nmis++; $display("FAIL sb_clear got=%b/%h want=0/0", hazard, busy); end
        nvec++; if (we !== 1'b0) begin nmis++; $display("FAIL sb_single_we got=%b want=0", we); end
        chk_r1 = 5'd0;
    endtask

    task automatic test_set_wins();
        set_req(2, 5'd9, DE);
        req_valid = 3'b100;
        tick();
        req_valid = 3'b000;
        issue_valid = 1'b1;
        issue_dest  = 5'd9;
        nvec++; if (we !== 1'b1 || wr !== 5'd9) begin nmis++; $display("FAIL sw_write got=%b/%0d want=1/9", we, wr); end
        tick();
        issue_valid = 1'b0;
        nvec++; if (busy !== 32'h0000_0200) begin nmis++; $display("FAIL sw_busy got=%h want=00000200", busy); end
        chk_r2 = 5'd9;
        #1;
        nvec++; if (hazard !== 1'b1) begin nmis++; $display("FAIL sw_hazard got=%b want=1", hazard); end
        req_valid = 3'b100;
        tick();
        req_valid = 3'b000;
        tick();
        nvec++; if (busy !== 32'h0 || hazard !== 1'b0) begin nmis++; $display("FAIL sw_clear got=%h/%b want=0/0", busy, hazard); end
        chk_r2 = 5'd0;
        issue_valid = 1'b1;
        issue_dest  = 5'd0;
        tick();
        issue_valid = 1'b0;
        nvec++; if (busy !== 32'h0) begin nmis++; $display("FAIL zero_busy got=%h want=0", busy); end
        nvec++; if (hazard !== 1'b0) begin nmis++; $display("FAIL zero_hazard got=%b want=0", hazard); end
    endtask

    task automatic test_zero_write();
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b001;
        #1;
        nvec++; if (req_ready !== 3'b001) begin nmis++; $display("FAIL z_ready got=%b want=001", req_ready); end
        tick();
        req_valid = 3'b000;
        nvec++; if (we !== 1'b0) begin nmis++; $display("FAIL z_we got=%b want=0", we); end
        tick();
    endtask

    task automatic test_reset_drop();
        set_req(0, 5'd6, 32'h0000_1234);
        req_valid = 3'b001;
        #1;
        nvec++; if (req_ready !== 3'b001) begin nmis++; $display("FAIL rd_ready got=%b want=001", req_ready); end
        reset = 1'b1;
        #1;
        nvec++; if (req_ready !== 3'b000) begin nmis++; $display("FAIL rd_ready_rst got=%b want=000", req_ready); end
        tick();
        reset = 1'b0;
        req_valid = 3'b000;
        nvec++; if (we !== 1'b0 || wr !== 5'd0 || wd !== 32'h0) begin nmis++; $display("FAIL rd_dropped got=%b/%0d/%h want=0/0/0", we, wr, wd); end
        tick();
        nvec++; if (we !== 1'b0) begin nmis++; $display("FAIL rd_never got=%b want=0", we); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 3'b000;
        req_addr = '0;
        req_data = '0;
        issue_valid = 1'b0;
        issue_dest = 5'd0;
        chk_r1 = 5'd0;
        chk_r2 = 5'd0;
        test_reset();
`ifdef MIPS_WB_ARB_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_scoreboard();
        test_set_wins();
        test_zero_write();
        test_reset_drop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
